mp_arbiter: RTL and testbench

MP_ARBITER -- requirements
Module: mp_arbiter

---
 rtl/mp_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mp_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mp_arbiter.sv
// Four-core round-robin arbiter in front of a shared-memory stage. It keeps up to two
// transactions in flight, routes each response back to the core that issued it, and
// returns a timed-out error response if the downstream stage stops answering.
module mp_arbiter #(
    parameter int AW    = 11,
    parameter int DW    = 8,
    parameter int NCORE = 4,
    parameter int TMO   = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NCORE-1:0]      c_req,
    output logic [NCORE-1:0]      c_gnt,
    input  logic [NCORE-1:0]      c_we,
    input  logic [4*NCORE-1:0]    c_opcode,
    input  logic [NCORE*AW-1:0]   c_addr,
    input  logic [NCORE*DW-1:0]   c_wdata,
    input  logic [32*NCORE-1:0]   c_burst_id,
    output logic [NCORE-1:0]      c_rvalid,
    output logic                  c_rerr,
    output logic [DW-1:0]         c_rdata,
    output logic                  m_req,
    output logic [1:0]            m_core_id,
    output logic [3:0]            m_opcode,
    output logic                  m_we,
    output logic [AW-1:0]         m_addr,
    output logic [DW-1:0]         m_wdata,
    output logic [31:0]           m_burst_id,
    input  logic                  m_gnt,
    input  logic                  m_rvalid,
    input  logic [DW-1:0]         m_rdata,
    output logic                  err_timeout,
    output logic                  err_unexp,
    output logic [1:0]            outstanding
);

    localparam int WDW = $clog2(TMO + 1);

    // Per-core request fields, unpacked from the flat buses
    logic [3:0]    op_a    [NCORE];
    logic [AW-1:0] addr_a  [NCORE];
    logic [DW-1:0] wdata_a [NCORE];
    logic [31:0]   bid_a   [NCORE];

    // Registered state
    logic [1:0]     rr_q, rr_d;
    logic [1:0]     tag_q [2];
    logic           rd_q, rd_d;
    logic           wr_q, wr_d;
    logic [1:0]     cnt_q, cnt_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic           err_timeout_q, err_timeout_d;
    logic           err_unexp_q, err_unexp_d;

    // Combinational control
    logic       any_req;
    logic       found;
    logic [1:0] cand;
    logic [1:0] sel;
    logic       fifo_empty;
    logic       issue_en;
    logic       req_int;
    logic       push;
    logic       rsp_pop;
    logic       tmo_pop;
    logic       pop;
    logic [1:0] head;

    genvar gi;
    generate
        for (gi = 0; gi < NCORE; gi++) begin : g_unpack
            assign op_a[gi]    = c_opcode[4*gi +: 4];
            assign addr_a[gi]  = c_addr[AW*gi +: AW];
            assign wdata_a[gi] = c_wdata[DW*gi +: DW];
            assign bid_a[gi]   = c_burst_id[32*gi +: 32];
        end
    endgenerate

    // Round-robin search: the core just after the last winner gets first look
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int k = 1; k <= NCORE; k++) begin
            cand = rr_q + 2'(k);
            if (!found && c_req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    assign any_req    = |c_req;
    assign fifo_empty = (cnt_q == 2'd0);
    // A full FIFO may still accept when a response frees a slot in the same cycle
    assign issue_en   = (cnt_q != 2'd2) || m_rvalid;
    assign req_int    = rst_n && any_req && issue_en;
    assign push       = req_int && m_gnt;
    assign rsp_pop    = rst_n && m_rvalid && !fifo_empty;
    assign tmo_pop    = rst_n && !fifo_empty && !m_rvalid && (wd_q == WDW'(TMO));
    assign pop        = rsp_pop || tmo_pop;
    assign head       = tag_q[rd_q];

    // Downstream request: selected core's fields, zeroed when idle
    always_comb begin
        m_req      = req_int;
        m_core_id  = '0;
        m_opcode   = '0;
        m_we       = 1'b0;
        m_addr     = '0;
        m_wdata    = '0;
        m_burst_id = '0;
        if (req_int) begin
            m_core_id  = sel;
            m_opcode   = op_a[sel];
            m_we       = c_we[sel];
            m_addr     = addr_a[sel];
            m_wdata    = wdata_a[sel];
            m_burst_id = bid_a[sel];
        end
    end

    generate
        for (gi = 0; gi < NCORE; gi++) begin : g_strobe
            assign c_gnt[gi]    = push && (sel == 2'(gi));
            assign c_rvalid[gi] = pop && (head == 2'(gi));
        end
    endgenerate

    assign c_rerr      = tmo_pop;
    assign c_rdata     = rsp_pop ? m_rdata : '0;
    assign err_timeout = err_timeout_q;
    assign err_unexp   = err_unexp_q;
    assign outstanding = cnt_q;

    always_comb begin
        rr_d          = push ? sel : rr_q;
        rd_d          = pop ? ~rd_q : rd_q;
        wr_d          = push ? ~wr_q : wr_q;
        cnt_d         = cnt_q + {1'b0, push} - {1'b0, pop};
        wd_d          = (pop || fifo_empty) ? '0 : wd_q + 1'b1;
        err_timeout_d = err_timeout_q || tmo_pop;
        err_unexp_d   = err_unexp_q || (m_rvalid && fifo_empty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q          <= 2'd3;
            rd_q          <= 1'b0;
            wr_q          <= 1'b0;
            cnt_q         <= '0;
            wd_q          <= '0;
            err_timeout_q <= 1'b0;
            err_unexp_q   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            rr_q          <= rr_d;
            rd_q          <= rd_d;
            wr_q          <= wr_d;
            cnt_q         <= cnt_d;
            wd_q          <= wd_d;
            err_timeout_q <= err_timeout_d;
            err_unexp_q   <= err_unexp_d;
            if (push) begin
                tag_q[wr_q] <= sel;
            end
        end
    end

endmodule

// File: tb/tb_mp_arbiter.sv
// Self-checking bench for mp_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based reference model.
module tb_mp_arbiter;

    localparam int AW  = 11;
    localparam int DW  = 8;
    localparam int TMO = 15;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [3:0]        c_req;
    logic [3:0]        c_gnt;
    logic [3:0]        c_we;
    logic [15:0]       c_opcode;
    logic [4*AW-1:0]   c_addr;
    logic [4*DW-1:0]   c_wdata;
    logic [127:0]      c_burst_id;
    logic [3:0]        c_rvalid;
    logic              c_rerr;
    logic [DW-1:0]     c_rdata;
    logic              m_req;
    logic [1:0]        m_core_id;
    logic [3:0]        m_opcode;
    logic              m_we;
    logic [AW-1:0]     m_addr;
    logic [DW-1:0]     m_wdata;
    logic [31:0]       m_burst_id;
    logic              m_gnt;
    logic              m_rvalid;
    logic [DW-1:0]     m_rdata;
    logic              err_timeout;
    logic              err_unexp;
    logic [1:0]        outstanding;

    always #5 clk = ~clk;

    mp_arbiter #(.AW(AW), .DW(DW), .NCORE(4), .TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_gnt(c_gnt), .c_we(c_we), .c_opcode(c_opcode),
        .c_addr(c_addr), .c_wdata(c_wdata), .c_burst_id(c_burst_id),
        .c_rvalid(c_rvalid), .c_rerr(c_rerr), .c_rdata(c_rdata),
        .m_req(m_req), .m_core_id(m_core_id), .m_opcode(m_opcode), .m_we(m_we),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_burst_id(m_burst_id),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .err_timeout(err_timeout), .err_unexp(err_unexp), .outstanding(outstanding)
    );

    // Core-side stimulus state: a core holds its request until granted
    bit            req_a  [4];
    logic [3:0]    op_a   [4];
    logic          we_a   [4];
    logic [AW-1:0] addr_a [4];
    logic [DW-1:0] wd_a   [4];
    logic [31:0]   bid_a  [4];

    // Reference model
    int rr;
    int q[$];
    int wd;
    bit f_tmo, f_unexp;

    // Expectations for the current cycle
    bit e_mreq, e_hs, e_pop_rsp, e_tmo;
    int e_sel, e_head;

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        rr = 3;
        q.delete();
        wd = 0;
        f_tmo = 0;
        f_unexp = 0;
    endtask

    task automatic pack();
        for (int i = 0; i < 4; i++) begin
            c_req[i]               = req_a[i];
            c_we[i]                = we_a[i];
            c_opcode[4*i +: 4]     = op_a[i];
            c_addr[AW*i +: AW]     = addr_a[i];
            c_wdata[DW*i +: DW]    = wd_a[i];
            c_burst_id[32*i +: 32] = bid_a[i];
        end
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 4; i++) begin
            req_a[i] = 0; op_a[i] = '0; we_a[i] = 0;
            addr_a[i] = '0; wd_a[i] = '0; bid_a[i] = '0;
        end
        m_gnt = 0; m_rvalid = 0; m_rdata = '0;
    endtask

    task automatic rand_fields(input int i);
        op_a[i]   = 4'($urandom);
        we_a[i]   = 1'($urandom);
        addr_a[i] = AW'($urandom);
        wd_a[i]   = DW'($urandom);
        bid_a[i]  = $urandom;
    endtask

    // Drive, let things settle, compare every output against the model
    task automatic eval();
        bit found;
        int c;
        logic [3:0] e_rv;
        pack();
        #1;
        if (!rst_n) model_reset();
        found = 0;
        e_sel = 0;
        for (int k = 1; k <= 4; k++) begin
            c = (rr + k) % 4;
            if (!found && req_a[c]) begin
                found = 1;
                e_sel = c;
            end
        end
        e_mreq    = rst_n && found && (q.size() < 2 || m_rvalid);
        e_hs      = e_mreq && m_gnt;
        e_pop_rsp = rst_n && m_rvalid && q.size() > 0;
        e_tmo     = rst_n && q.size() > 0 && !m_rvalid && wd == TMO;
        e_head    = (q.size() > 0) ? q[0] : 0;
        e_rv      = (e_pop_rsp || e_tmo) ? 4'(1 << e_head) : 4'd0;

        chk("m_req",      32'(m_req),      32'(e_mreq));
        chk("c_gnt",      32'(c_gnt),      e_hs ? 32'(1 << e_sel) : 32'd0);
        chk("m_core_id",  32'(m_core_id),  e_mreq ? 32'(e_sel) : 32'd0);
        chk("m_opcode",   32'(m_opcode),   e_mreq ? 32'(op_a[e_sel]) : 32'd0);
        chk("m_we",       32'(m_we),       e_mreq ? 32'(we_a[e_sel]) : 32'd0);
        chk("m_addr",     32'(m_addr),     e_mreq ? 32'(addr_a[e_sel]) : 32'd0);
        chk("m_wdata",    32'(m_wdata),    e_mreq ? 32'(wd_a[e_sel]) : 32'd0);
        chk("m_burst_id", m_burst_id,      e_mreq ? bid_a[e_sel] : 32'd0);
        chk("c_rvalid",   32'(c_rvalid),   32'(e_rv));
        if (e_rv != 0 || !rst_n) begin
            chk("c_rerr",  32'(c_rerr),  32'(e_tmo));
            chk("c_rdata", 32'(c_rdata), e_pop_rsp ? 32'(m_rdata) : 32'd0);
        end
        chk("err_timeout", 32'(err_timeout), 32'(f_tmo));
        chk("err_unexp",   32'(err_unexp),   32'(f_unexp));
        chk("outstanding", 32'(outstanding), 32'(q.size()));
    endtask

    // Advance the model across the rising edge, return at the next falling edge
    task automatic tick();
        int nwd;
        @(posedge clk);
        if (rst_n) begin
            nwd = (e_pop_rsp || e_tmo || q.size() == 0) ? 0 : wd + 1;
            if (m_rvalid && q.size() == 0) f_unexp = 1;
            if (e_tmo) f_tmo = 1;
            if (e_pop_rsp || e_tmo) void'(q.pop_front());
            if (e_hs) begin
                q.push_back(e_sel);
                rr = e_sel;
                req_a[e_sel] = 0;
            end
            wd = nwd;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 0;
        clear_inputs();
        eval();
        tick();
        rst_n = 1;
    endtask

    initial begin
        int stall;
        rst_n = 0;
        clear_inputs();
        model_reset();
        @(negedge clk);

        // Outputs held at zero during reset even with every core requesting
        for (int i = 0; i < 4; i++) begin req_a[i] = 1; rand_fields(i); end
        m_gnt = 1; m_rvalid = 1; m_rdata = 8'h3C;
        eval();
        chk("rst_m_req", 32'(m_req), 32'd0);
        chk("rst_c_rvalid", 32'(c_rvalid), 32'd0);
        tick();

        // Single write from core 0, response returns next cycle
        do_reset();
        req_a[0] = 1; we_a[0] = 1; op_a[0] = 4'h2;
        addr_a[0] = 11'h010; wd_a[0] = 8'hA5; bid_a[0] = 32'hCAFE0001;
        m_gnt = 1;
        eval();
        chk("single_m_req", 32'(m_req), 32'd1);
        chk("single_core_id", 32'(m_core_id), 32'd0);
        chk("single_c_gnt", 32'(c_gnt), 32'h1);
        chk("single_m_addr", 32'(m_addr), 32'h010);
        tick();
        m_rvalid = 1; m_rdata = 8'hA5;
        eval();
        chk("single_c_rvalid", 32'(c_rvalid), 32'h1);
        chk("single_c_rdata", 32'(c_rdata), 32'hA5);
        tick();

        // All cores requesting: grants rotate 0,1,2,3,0; responses follow one cycle later
        do_reset();
        for (int i = 0; i < 4; i++) rand_fields(i);
        m_gnt = 1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            for (int i = 0; i < 4; i++) req_a[i] = 1;
            m_rvalid = (cyc >= 1);
            m_rdata  = DW'(8'h40 + cyc);
            eval();
            if (cyc < 5) chk("rr_order", 32'(m_core_id), 32'(cyc % 4));
            if (cyc >= 1) chk("rr_resp", 32'(c_rvalid), 32'(1 << ((cyc - 1) % 4)));
            tick();
        end

        // Back-to-back issue with 2-cycle latency keeps two in flight
        do_reset();
        rand_fields(1);
        m_gnt = 1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            req_a[1] = 1;
            m_rvalid = (cyc >= 2);
            m_rdata  = DW'(cyc);
            eval();
            if (cyc >= 2) begin
                chk("b2b_outstanding", 32'(outstanding), 32'd2);
                chk("b2b_c_gnt", 32'(c_gnt), 32'h2);
            end
            tick();
        end

        // No response: watchdog reads 0 in the first waiting cycle and fires when it reads TMO
        do_reset();
        rand_fields(0);
        req_a[0] = 1; m_gnt = 1;
        eval();
        tick();
        m_gnt = 0;
        for (int n = 1; n <= TMO + 1; n++) begin
            eval();
            if (n == TMO) chk("tmo_early", 32'(c_rvalid), 32'd0);
            if (n == TMO + 1) begin
                chk("tmo_c_rvalid", 32'(c_rvalid), 32'h1);
                chk("tmo_c_rerr", 32'(c_rerr), 32'd1);
            end
            tick();
        end
        eval();
        chk("tmo_flag", 32'(err_timeout), 32'd1);
        chk("tmo_outstanding", 32'(outstanding), 32'd0);
        tick();

        // Unexpected response is dropped and the flag sticks
        do_reset();
        m_rvalid = 1; m_rdata = 8'h77;
        eval();
        chk("unexp_c_rvalid", 32'(c_rvalid), 32'd0);
        tick();
        m_rvalid = 0;
        for (int n = 0; n < 4; n++) begin
            eval();
            chk("unexp_sticky", 32'(err_unexp), 32'd1);
            tick();
        end

        // Reset with two in flight, then a stale response
        do_reset();
        m_gnt = 1;
        rand_fields(2); rand_fields(3);
        req_a[2] = 1; eval(); tick();
        req_a[3] = 1; eval(); tick();
        for (int i = 0; i < 4; i++) begin req_a[i] = 1; rand_fields(i); end
        eval();
        chk("pre_rst_outstanding", 32'(outstanding), 32'd2);
        rst_n = 0;
        eval();
        chk("midrst_outstanding", 32'(outstanding), 32'd0);
        chk("midrst_m_req", 32'(m_req), 32'd0);
        tick();
        rst_n = 1; m_gnt = 0;
        eval();
        chk("postrst_core_id", 32'(m_core_id), 32'd0);
        tick();
        m_rvalid = 1;
        eval();
        chk("stale_c_rvalid", 32'(c_rvalid), 32'd0);
        tick();
        m_rvalid = 0;
        eval();
        chk("stale_unexp", 32'(err_unexp), 32'd1);
        tick();

        // Randomized traffic
        do_reset();
        stall = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req_a[i] && $urandom_range(0, 1) == 1) begin
                    req_a[i] = 1;
                    rand_fields(i);
                end
            end
            m_gnt   = ($urandom_range(0, 9) < 7);
            m_rdata = DW'($urandom);
            if (stall > 0) begin
                m_rvalid = 0;
                stall--;
            end else begin
                if (q.size() > 0) m_rvalid = ($urandom_range(0, 9) < 4);
                else              m_rvalid = ($urandom_range(0, 39) == 0);
                if ($urandom_range(0, 149) == 0) stall = $urandom_range(18, 25);
            end
            rst_n = ($urandom_range(0, 499) != 0);
            eval();
            tick();
        end
        rst_n = 1;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
